// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: drives the PC register, issues imem reads and hands instructions to IF/ID.
// Define IF_FETCH_MISALIGN_TRAP_EN to add the fetch_fault output and trap on misaligned PCs.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic [31:0] pc,
    output logic        pc_inc,
    output logic        pc_write,
    output logic [31:0] pc_next,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        ifid_valid,
    input  logic        ifid_ready,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
`ifdef IF_FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FULL = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_req_pc;
    logic        r_squash;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        w_misaligned;
    logic        w_req_fire;
    logic        w_resp_take;

`ifdef IF_FETCH_MISALIGN_TRAP_EN
    logic r_fetch_fault;

    assign w_misaligned = (pc[1:0] != 2'b00);
    assign fetch_fault  = r_fetch_fault;

    // A misaligned PC parks the FSM in REQ; only a redirect can clear the fault.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_fault <= 1'b0;
        end else if (r_state == S_REQ && w_misaligned) begin
            r_fetch_fault <= 1'b1;
        end
    end
`else
    assign w_misaligned = 1'b0;
`endif

    assign imem_req_addr  = pc & 32'hFFFF_FFFC;
    assign imem_req_valid = (r_state == S_REQ) && !w_misaligned;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign pc_inc         = w_req_fire && !redirect_valid;
    assign pc_write       = reset_n && redirect_valid;
    assign pc_next        = pc_write ? redirect_pc : 32'h0000_0000;
    assign w_resp_take    = (r_state == S_WAIT) && imem_resp_valid && !r_squash && !redirect_valid;

    assign ifid_valid = r_ifid_valid;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;

    // A redirect in WAIT without a response keeps waiting so the stale reply can be dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (fetch_en) w_state_nxt = S_REQ;
            S_REQ:  if (w_req_fire) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (redirect_valid)  w_state_nxt = S_REQ;
                    else if (r_squash)   w_state_nxt = fetch_en ? S_REQ : S_IDLE;
                    else                 w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (redirect_valid)      w_state_nxt = S_REQ;
                else if (ifid_ready)     w_state_nxt = fetch_en ? S_REQ : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_req_pc     <= RESET_PC;
            r_squash     <= 1'b0;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= RESET_PC;
            r_ifid_instr <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_fire) begin
                r_req_pc <= imem_req_addr;
            end
            // Squash marks an accepted request whose reply must never reach IF/ID.
            if (r_state == S_REQ && w_req_fire && redirect_valid) begin
                r_squash <= 1'b1;
            end else if (r_state == S_WAIT) begin
                if (imem_resp_valid)     r_squash <= 1'b0;
                else if (redirect_valid) r_squash <= 1'b1;
            end
            if (w_resp_take) begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= r_req_pc;
                r_ifid_instr <= imem_resp_data;
            end else if (r_state == S_FULL && (redirect_valid || ifid_ready)) begin
                r_ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl: PC register + memory models, scoreboard of expected fetch stream.
// The expected stream is program order from the current fetch target; any redirect restarts it.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5A5A5;

    logic        clk;
    logic        reset_n;
    logic        fetch_en;
    logic [31:0] pc;
    logic        pc_inc;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
`ifdef IF_FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    int assertCount = 0;
    int failCount   = 0;
    int deliveries  = 0;
    int cycleCnt    = 0;
    int lastHsCycle = 0;
    logic [31:0] lastPc = 32'h0;
    bit hsPrevValid = 0;
    bit tputChk     = 0;

    int reqPct  = 100;
    int ifidPct = 100;
    int memLat  = 1;
    bit latRand = 0;
    bit memPending;
    logic [31:0] memAddr;
    int memCnt;

    logic [31:0] expQ[$];

    if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .pc             (pc),
        .pc_inc         (pc_inc),
        .pc_write       (pc_write),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .ifid_valid     (ifid_valid),
        .ifid_ready     (ifid_ready),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr)
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: wait expired, got no event, required one (t=%0t)", name, $time);
    endtask

    // PC register and instruction memory models: sample before the edge, update just after it.
    initial begin
        logic acc, respShown, pcI, pcW;
        logic [31:0] accAddr, pcN;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        ifid_ready      = 1'b0;
        pc              = RESET_PC;
        memPending      = 1'b0;
        memAddr         = 32'h0;
        memCnt          = 0;
        forever begin
            @(negedge clk);
            acc       = reset_n && imem_req_valid && imem_req_ready;
            accAddr   = imem_req_addr;
            respShown = imem_resp_valid;
            pcI       = pc_inc;
            pcW       = pc_write;
            pcN       = pc_next;
            @(posedge clk);
            #1;
            if (!reset_n)  pc = RESET_PC;
            else if (pcW)  pc = pcN;
            else if (pcI)  pc = pc + 32'd4;
            if (respShown) begin
                imem_resp_valid = 1'b0;
                memPending      = 1'b0;
            end
            if (acc) begin
                memPending = 1'b1;
                memAddr    = accAddr;
                memCnt     = latRand ? int'($urandom_range(1, 3)) : memLat;
            end
            if (memPending && !imem_resp_valid) begin
                memCnt--;
                if (memCnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = memAddr ^ KEY;
                end
            end
            if (!imem_resp_valid) imem_resp_data = $urandom;
            imem_req_ready = (int'($urandom_range(0, 99)) < reqPct);
            ifid_ready     = (int'($urandom_range(0, 99)) < ifidPct);
        end
    end

    // Monitor / scoreboard: rules checked every cycle, deliveries popped from expQ.
    initial begin
        bit prevReqStall, prevIfidStall;
        logic [31:0] expPc;
        prevReqStall  = 1'b0;
        prevIfidStall = 1'b0;
        forever begin
            @(negedge clk);
            cycleCnt++;
            if (reset_n !== 1'b1) begin
                expQ.delete();
                expQ.push_back(RESET_PC);
                hsPrevValid   = 1'b0;
                prevReqStall  = 1'b0;
                prevIfidStall = 1'b0;
            end else begin
                checkBit("pulse_exclusive", pc_inc && pc_write, 1'b0);
                checkBit("pc_write", pc_write, redirect_valid);
                if (redirect_valid) checkOutput("pc_next", pc_next, redirect_pc);
                checkBit("pc_inc", pc_inc, imem_req_valid && imem_req_ready && !redirect_valid);
                checkOutput("req_addr", imem_req_addr, {pc[31:2], 2'b00});
                if (imem_req_valid) begin
                    checkBit("one_outstanding", memPending, 1'b0);
                    checkBit("req_while_full", ifid_valid, 1'b0);
                end
                if (prevReqStall) checkBit("req_hold", imem_req_valid, 1'b1);
                if (prevIfidStall) begin
                    checkBit("ifid_hold_valid", ifid_valid, 1'b1);
                    if (expQ.size() > 0) begin
                        checkOutput("ifid_hold_pc", ifid_pc, expQ[0]);
                        checkOutput("ifid_hold_instr", ifid_instr, expQ[0] ^ KEY);
                    end
                end
                if (ifid_valid && ifid_ready) begin
                    if (expQ.size() == 0) begin
                        reportTimeout("scoreboard_empty");
                    end else begin
                        expPc = expQ.pop_front();
                        checkOutput("ifid_pc", ifid_pc, expPc);
                        checkOutput("ifid_instr", ifid_instr, expPc ^ KEY);
                        expQ.push_back(expPc + 32'd4);
                    end
                    if (tputChk && hsPrevValid) checkOutput("throughput", 32'(cycleCnt - lastHsCycle), 32'd3);
                    hsPrevValid = 1'b1;
                    lastHsCycle = cycleCnt;
                    lastPc      = ifid_pc;
                    deliveries++;
                end
                if (redirect_valid) begin
                    expQ.delete();
                    expQ.push_back(redirect_pc);
                end
                prevReqStall  = imem_req_valid && !imem_req_ready && !redirect_valid;
                prevIfidStall = ifid_valid && !ifid_ready && !redirect_valid;
            end
        end
    end

    task automatic waitDeliveries(input int target, input int budget, input string name);
        int n = 0;
        while (deliveries < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (deliveries < target) reportTimeout(name);
    endtask

    task automatic waitAccept(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) found = 1'b1;
        end
        if (!found) reportTimeout(name);
    endtask

    task automatic waitReqStall(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && !imem_req_ready) found = 1'b1;
        end
        if (!found) reportTimeout(name);
    endtask

    task automatic pulseRedirect(input logic [31:0] target);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    // Randomised traffic: random readiness, latency, redirects and fetch_en toggles.
    task automatic applyStimulus(input int cycles);
        latRand = 1'b1;
        reqPct  = 70;
        ifidPct = 70;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            redirect_valid = (int'($urandom_range(0, 99)) < 8);
            redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            if (int'($urandom_range(0, 99)) < 3) fetch_en = ~fetch_en;
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        latRand        = 1'b0;
        reqPct         = 100;
        ifidPct        = 100;
    endtask

    initial begin
        int d0;
        logic [31:0] holdAddr;
        reset_n        = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #3;
        reset_n = 1'b0;
        #1;
        checkBit("reset_ifid_valid", ifid_valid, 1'b0);
        checkOutput("reset_ifid_pc", ifid_pc, RESET_PC);
        checkOutput("reset_ifid_instr", ifid_instr, 32'h0);
        checkBit("reset_req_valid", imem_req_valid, 1'b0);
        checkBit("reset_pc_inc", pc_inc, 1'b0);
        checkBit("reset_pc_write", pc_write, 1'b0);
        checkOutput("reset_pc_next", pc_next, 32'h0);
        checkOutput("reset_req_addr", imem_req_addr, RESET_PC);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        $display("[TB] sequential fetch, 1-cycle memory");
        tputChk  = 1'b1;
        fetch_en = 1'b1;
        waitDeliveries(4, 40, "seq_fetch");
        checkOutput("seq_last_pc", lastPc, 32'h0000_000C);
        tputChk  = 1'b0;
        ifidPct  = 0;

        $display("[TB] IF/ID stall holding pc 0x10");
        begin
            bit found = 1'b0;
            for (int i = 0; i < 30 && !found; i++) begin
                @(negedge clk);
                if (ifid_valid) found = 1'b1;
            end
            if (!found) reportTimeout("stall_full");
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checkBit("stall_valid", ifid_valid, 1'b1);
            checkOutput("stall_pc", ifid_pc, 32'h0000_0010);
            checkOutput("stall_instr", ifid_instr, 32'h0000_0010 ^ KEY);
            checkBit("stall_no_req", imem_req_valid, 1'b0);
            checkBit("stall_no_inc", pc_inc, 1'b0);
        end
        ifidPct = 100;
        waitDeliveries(5, 20, "stall_release");
        checkOutput("stall_release_pc", lastPc, 32'h0000_0010);

        $display("[TB] redirect during WAIT");
        memLat = 3;
        waitAccept("wait_redirect_accept");
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        checkBit("wait_redir_pc_write", pc_write, 1'b1);
        checkOutput("wait_redir_pc_next", pc_next, 32'h0000_0200);
        checkBit("wait_redir_pc_inc", pc_inc, 1'b0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        memLat = 1;
        d0 = deliveries;
        waitDeliveries(d0 + 1, 40, "wait_redirect_deliver");
        checkOutput("wait_redirect_target", lastPc, 32'h0000_0200);

        $display("[TB] redirect on the accept cycle");
        reqPct = 0;
        waitReqStall("accept_redirect_stall");
        pulseRedirect(32'h0000_0040);
        @(negedge clk);
        checkOutput("accept_redir_addr40", imem_req_addr, 32'h0000_0040);
        checkBit("accept_redir_valid40", imem_req_valid, 1'b1);
        reqPct = 100;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        @(negedge clk);
        checkBit("accept_redir_fire", imem_req_valid && imem_req_ready, 1'b1);
        checkBit("accept_redir_pc_inc", pc_inc, 1'b0);
        checkBit("accept_redir_pc_write", pc_write, 1'b1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        d0 = deliveries;
        waitDeliveries(d0 + 1, 40, "accept_redirect_deliver");
        checkOutput("accept_redirect_target", lastPc, 32'h0000_0080);

        $display("[TB] memory not ready for 4 cycles");
        reqPct = 0;
        waitReqStall("req_stall");
        holdAddr = {pc[31:2], 2'b00};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkBit("req_stall_valid", imem_req_valid, 1'b1);
            checkOutput("req_stall_addr", imem_req_addr, holdAddr);
            checkBit("req_stall_no_inc", pc_inc, 1'b0);
        end
        reqPct = 100;
        @(negedge clk);
        checkBit("req_stall_accept_inc", pc_inc, 1'b1);
        checkOutput("req_stall_accept_addr", imem_req_addr, holdAddr);

        $display("[TB] reset asserted in WAIT");
        memLat = 4;
        waitAccept("reset_wait_accept");
        @(posedge clk);
        #2;
        reset_n  = 1'b0;
        pc       = RESET_PC;
        fetch_en = 1'b0;
        #1;
        checkBit("midreset_ifid_valid", ifid_valid, 1'b0);
        checkOutput("midreset_ifid_pc", ifid_pc, RESET_PC);
        checkOutput("midreset_ifid_instr", ifid_instr, 32'h0);
        checkBit("midreset_req_valid", imem_req_valid, 1'b0);
        checkBit("midreset_pc_inc", pc_inc, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkBit("stale_resp_ignored", ifid_valid, 1'b0);
            checkBit("stale_no_req", imem_req_valid, 1'b0);
        end
        memLat   = 1;
        fetch_en = 1'b1;
        d0 = deliveries;
        waitDeliveries(d0 + 1, 40, "post_reset_deliver");
        checkOutput("post_reset_pc", lastPc, RESET_PC);

        $display("[TB] randomised traffic");
        d0 = deliveries;
        applyStimulus(1500);
        checkBit("random_progress", (deliveries - d0) >= 30, 1'b1);

`ifdef IF_FETCH_MISALIGN_TRAP_EN
        $display("[TB] misaligned fetch trap");
        waitAccept("misalign_sync");
        pulseRedirect(32'h0000_0102);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkBit("misalign_no_req", imem_req_valid, 1'b0);
        end
        checkBit("misalign_fault_set", fetch_fault, 1'b1);
        pulseRedirect(32'h0000_0104);
        @(negedge clk);
        checkBit("misalign_fault_clear", fetch_fault, 1'b0);
        d0 = deliveries;
        waitDeliveries(d0 + 1, 40, "misalign_resume");
        checkOutput("misalign_resume_pc", lastPc, 32'h0000_0104);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
